// File: rtl/nw_vc_input_port_cr.sv
// Virtual-channel router input port: per-VC flit FIFOs, per-VC packet FSMs holding the
// granted downstream VC, outgoing VC rewrite on switch traversal and registered credit return.
module nw_vc_input_port_cr #(
  parameter int num_vcs       = 4,
  parameter int buffer_length = 8,
  parameter int data_width    = 32,
  parameter int route_width   = 5,
  parameter bit bypass_new_vc = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [$clog2(num_vcs)-1:0]          push_vc,
  input  logic                                in_head,
  input  logic                                in_tail,
  input  logic [route_width-1:0]              in_route,
  input  logic [data_width-1:0]               in_data,
  input  logic [num_vcs-1:0]                  pop,
  input  logic [num_vcs-1:0][num_vcs-1:0]     vc_new,
  input  logic [num_vcs-1:0]                  vc_new_valid,
  output logic [num_vcs-1:0]                  vc_req,
  output logic [num_vcs-1:0]                  vc_active,
  output logic [num_vcs-1:0][route_width-1:0] route_out,
  output logic [num_vcs-1:0]                  not_empty,
  output logic                                out_valid,
  output logic                                out_head,
  output logic                                out_tail,
  output logic [num_vcs-1:0]                  out_vc,
  output logic [data_width-1:0]               out_data,
  output logic                                credit_valid,
  output logic [$clog2(num_vcs)-1:0]          credit_vc,
  output logic [2:0]                          err
);

  localparam int vc_w      = $clog2(num_vcs);
  localparam int ptr_w     = $clog2(buffer_length);
  localparam int err_proto = 2;
  localparam int err_under = 1;
  localparam int err_over  = 0;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [route_width-1:0] route;
    logic [data_width-1:0]  data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, WAIT_VC, ACTIVE} vc_state_t;

  flit_t                             mem [num_vcs][buffer_length];
  logic      [ptr_w-1:0]             rd_ptr [num_vcs];
  logic      [ptr_w-1:0]             wr_ptr [num_vcs];
  logic      [ptr_w:0]               count  [num_vcs];
  vc_state_t                         state_q [num_vcs];
  vc_state_t                         state_d [num_vcs];
  logic      [num_vcs-1:0][num_vcs-1:0] vc_reg_q, vc_reg_d;

  flit_t              in_flit;
  flit_t              front [num_vcs];
  logic [num_vcs-1:0] empty, full, grant_ok, pop_ok, push_ok;
  logic               multi_pop;
  logic               pop_any;
  logic [vc_w-1:0]    pop_idx;
  logic [2:0]         err_set;

  assign in_flit = '{head: in_head, tail: in_tail, route: in_route, data: in_data};

  // Acceptance: a VC pops when it holds a downstream VC, or (bypass) is being granted one now.
  always_comb begin
    multi_pop = ($countones(pop) > 1);
    for (int v = 0; v < num_vcs; v++) begin
      front[v]    = mem[v][rd_ptr[v]];
      empty[v]    = (count[v] == '0);
      full[v]     = (count[v] == (ptr_w+1)'(buffer_length));
      grant_ok[v] = vc_new_valid[v] && (vc_new[v] != '0);
      pop_ok[v]   = pop[v] && !multi_pop && !empty[v] &&
                    ((state_q[v] == ACTIVE) ||
                     (bypass_new_vc && (state_q[v] == WAIT_VC) && grant_ok[v]));
      push_ok[v]  = push && (push_vc == vc_w'(v)) && (!full[v] || pop_ok[v]);
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pop_any   = |pop_ok;
    pop_idx   = '0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_vc    = '0;
    out_data  = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (pop_ok[v]) begin
        pop_idx  = vc_w'(v);
        out_head = front[v].head;
        out_tail = front[v].tail;
        out_data = front[v].data;
        out_vc   = (state_q[v] == ACTIVE) ? vc_reg_q[v] : vc_new[v];
      end
    end
    out_valid = pop_any;
  end

  always_comb begin
    err_set = '0;
    if (multi_pop) err_set[err_proto] = 1'b1;
    for (int v = 0; v < num_vcs; v++) begin
      if (pop[v] && !multi_pop && !pop_ok[v]) begin
        if (empty[v]) err_set[err_under] = 1'b1;
        else          err_set[err_proto] = 1'b1;
      end
      if ((state_q[v] == WAIT_VC) && vc_new_valid[v] && (vc_new[v] == '0))
        err_set[err_proto] = 1'b1;
    end
    if (push) begin
      if (full[push_vc] && !pop_ok[push_vc]) err_set[err_over] = 1'b1;
      if (!in_head && empty[push_vc] && (state_q[push_vc] == IDLE))
        err_set[err_proto] = 1'b1;
    end
  end

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      state_d[v]  = state_q[v];
      vc_reg_d[v] = vc_reg_q[v];
      case (state_q[v])
        IDLE:
          if (!empty[v] && front[v].head) state_d[v] = WAIT_VC;
        WAIT_VC:
          if (grant_ok[v]) begin
            // A single-flit packet leaving through the bypass never holds the VC.
            if (pop_ok[v] && front[v].tail) begin
              state_d[v] = IDLE;
            end else begin
              state_d[v]  = ACTIVE;
              vc_reg_d[v] = vc_new[v];
            end
          end
        ACTIVE:
          if (pop_ok[v] && front[v].tail) begin
            state_d[v]  = IDLE;
            vc_reg_d[v] = '0;
          end
        default: state_d[v] = IDLE;
      endcase
      vc_req[v]    = (state_q[v] == WAIT_VC);
      vc_active[v] = (state_q[v] == ACTIVE);
      not_empty[v] = !empty[v];
      route_out[v] = empty[v] ? '0 : front[v].route;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      for (int v = 0; v < num_vcs; v++) begin
        rd_ptr[v]   <= '0;
        wr_ptr[v]   <= '0;
        count[v]    <= '0;
        state_q[v]  <= IDLE;
        vc_reg_q[v] <= '0;
      end
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      err          <= '0;
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        if (push_ok[v]) wr_ptr[v] <= wr_ptr[v] + ptr_w'(1);
        if (pop_ok[v])  rd_ptr[v] <= rd_ptr[v] + ptr_w'(1);
        count[v]    <= count[v] + (ptr_w+1)'(push_ok[v]) - (ptr_w+1)'(pop_ok[v]);
        state_q[v]  <= state_d[v];
        vc_reg_q[v] <= vc_reg_d[v];
      end
      credit_valid <= pop_any;
      credit_vc    <= pop_idx;
      err          <= err | err_set;
    end
  end

  // NOTE: flit storage is not reset; the occupancy counters alone define valid entries.
  always_ff @(posedge clk) begin
    for (int v = 0; v < num_vcs; v++)
      if (push_ok[v]) mem[v][wr_ptr[v]] <= in_flit;
  end

endmodule

// File: tb/tb_nw_vc_input_port_cr.sv
// Self-checking bench for nw_vc_input_port_cr: directed scenarios plus random traffic,
// all compared every cycle against a queue-based packet model.
module tb_nw_vc_input_port_cr;

  localparam int  nv     = 4;
  localparam int  bl     = 8;
  localparam bit  bypass = 1'b1;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [4:0]  route;
    logic [31:0] data;
  } mflit_t;

  logic                clk = 1'b0;
  logic                rst, push, in_head, in_tail;
  logic [1:0]          push_vc;
  logic [4:0]          in_route;
  logic [31:0]         in_data;
  logic [3:0]          pop, vc_new_valid;
  logic [3:0][3:0]     vc_new;
  logic [3:0]          vc_req, vc_active, not_empty, out_vc;
  logic [3:0][4:0]     route_out;
  logic                out_valid, out_head, out_tail, credit_valid;
  logic [31:0]         out_data;
  logic [1:0]          credit_vc;
  logic [2:0]          err;

  int tests = 0, fails = 0;
  int credits_seen = 0, pops_seen = 0;

  mflit_t      q [nv][$];
  bit          req [nv];
  logic [3:0]  held [nv];
  logic [2:0]  m_err;
  bit          m_cv;
  logic [1:0]  m_cvc;

  nw_vc_input_port_cr #(.num_vcs(nv), .buffer_length(bl), .data_width(32),
                        .route_width(5), .bypass_new_vc(bypass)) dut (
    .clk(clk), .rst(rst), .push(push), .push_vc(push_vc), .in_head(in_head),
    .in_tail(in_tail), .in_route(in_route), .in_data(in_data), .pop(pop),
    .vc_new(vc_new), .vc_new_valid(vc_new_valid), .vc_req(vc_req),
    .vc_active(vc_active), .route_out(route_out), .not_empty(not_empty),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .out_vc(out_vc), .out_data(out_data), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit grant_ok(int v);
    return vc_new_valid[v] && (vc_new[v] != 4'b0000);
  endfunction

  // Packet rules: a VC forwards once it holds a downstream VC, or while being granted one.
  function automatic bit accepts(int v);
    if (!pop[v] || $countones(pop) != 1 || q[v].size() == 0) return 1'b0;
    if (held[v] != 4'b0000) return 1'b1;
    return bypass && req[v] && grant_ok(v);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < nv; v++) begin
      q[v].delete();
      req[v]  = 1'b0;
      held[v] = 4'b0000;
    end
    m_err = 3'b000;
    m_cv  = 1'b0;
    m_cvc = 2'd0;
  endtask

  task automatic model_check();
    logic [3:0] e_req, e_act, e_ne;
    logic [3:0] e_vc;
    int sel = -1;
    for (int v = 0; v < nv; v++) begin
      e_req[v] = req[v];
      e_act[v] = (held[v] != 4'b0000);
      e_ne[v]  = (q[v].size() > 0);
      if (accepts(v)) sel = v;
    end
    check("vc_req", vc_req, e_req);
    check("vc_active", vc_active, e_act);
    check("not_empty", not_empty, e_ne);
    check("err", err, m_err);
    check("credit_valid", credit_valid, m_cv);
    if (m_cv) check("credit_vc", credit_vc, m_cvc);
    if (credit_valid === 1'b1) credits_seen++;
    check("out_valid", out_valid, sel >= 0);
    if (out_valid === 1'b1) pops_seen++;
    if (sel >= 0) begin
      e_vc = (held[sel] != 4'b0000) ? held[sel] : vc_new[sel];
      check("out_head", out_head, q[sel][0].head);
      check("out_tail", out_tail, q[sel][0].tail);
      check("out_data", out_data, q[sel][0].data);
      check("out_vc", out_vc, e_vc);
    end
    for (int v = 0; v < nv; v++)
      if (q[v].size() > 0) check("route_out", route_out[v], q[v][0].route);
  endtask

  task automatic model_update();
    int     npop = $countones(pop);
    int     pv   = int'(push_vc);
    bit     acc [nv];
    int     sz  [nv];
    bit     fh  [nv];
    mflit_t popped [nv];
    mflit_t f;
    for (int v = 0; v < nv; v++) begin
      sz[v]  = q[v].size();
      acc[v] = accepts(v);
      fh[v]  = (sz[v] > 0) && q[v][0].head;
      popped[v] = '0;
    end
    if (npop > 1) m_err[2] = 1'b1;
    for (int v = 0; v < nv; v++) begin
      if (pop[v] && npop == 1 && !acc[v]) m_err[(sz[v] == 0) ? 1 : 2] = 1'b1;
      if (req[v] && vc_new_valid[v] && vc_new[v] == 4'b0000) m_err[2] = 1'b1;
    end
    if (push) begin
      if (sz[pv] == bl && !acc[pv]) m_err[0] = 1'b1;
      if (!in_head && sz[pv] == 0 && !req[pv] && held[pv] == 4'b0000) m_err[2] = 1'b1;
    end
    m_cv  = 1'b0;
    m_cvc = 2'd0;
    for (int v = 0; v < nv; v++) begin
      if (acc[v]) begin
        m_cv  = 1'b1;
        m_cvc = 2'(v);
        popped[v] = q[v].pop_front();
      end
    end
    if (push && (sz[pv] < bl || acc[pv])) begin
      f.head = in_head; f.tail = in_tail; f.route = in_route; f.data = in_data;
      q[pv].push_back(f);
    end
    for (int v = 0; v < nv; v++) begin
      if (req[v]) begin
        if (grant_ok(v)) begin
          req[v] = 1'b0;
          if (!(acc[v] && popped[v].tail)) held[v] = vc_new[v];
        end
      end else if (held[v] != 4'b0000) begin
        if (acc[v] && popped[v].tail) held[v] = 4'b0000;
      end else if (fh[v]) begin
        req[v] = 1'b1;
      end
    end
  endtask

  task automatic clear_inputs();
    push = 1'b0; push_vc = 2'd0; in_head = 1'b0; in_tail = 1'b0;
    in_route = 5'd0; in_data = 32'd0; pop = 4'b0000;
    vc_new = '0; vc_new_valid = 4'b0000;
  endtask

  task automatic set_push(input int vc, input bit h, input bit t, input int route, input logic [31:0] d);
    push = 1'b1; push_vc = 2'(vc); in_head = h; in_tail = t;
    in_route = 5'(route); in_data = d;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cycle();
    #4;
    model_check();
    if (rst) model_reset();
    else     model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Grants every requesting VC in mask and pops one VC that can forward this cycle.
  task automatic auto_drive(input logic [3:0] mask, input int start);
    int v;
    for (int i = 0; i < nv; i++)
      if (mask[i] && req[i]) begin
        vc_new_valid[i] = 1'b1;
        vc_new[i]       = 4'b0001 << ((i + 1) % nv);
      end
    for (int k = 0; k < nv; k++) begin
      v = (start + k) % nv;
      if (pop == 4'b0000 && mask[v] && q[v].size() > 0 && (held[v] != 4'b0000 || req[v]))
        pop[v] = 1'b1;
    end
  endtask

  initial begin
    int n, pushed;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_vc_req", vc_req, 4'b0000);
    check("rst_vc_active", vc_active, 4'b0000);
    check("rst_not_empty", not_empty, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vc", out_vc, 4'b0000);
    check("rst_credit", {credit_valid, credit_vc}, 3'b000);
    check("rst_err", err, 3'b000);
    check("rst_route_out", route_out, 20'd0);
    rst = 1'b0;

    // Three-flit packet on VC2, route 5, granted downstream VC3.
    clear_inputs(); set_push(2, 1, 0, 5, 32'hA0); cycle();
    clear_inputs(); set_push(2, 0, 0, 5, 32'hA1); cycle();
    clear_inputs(); set_push(2, 0, 1, 5, 32'hA2);
    check("A_vc_req_c2", vc_req[2], 1'b1);
    check("A_route_c2", route_out[2], 5'd5);
    cycle();
    clear_inputs(); vc_new[2] = 4'b1000; vc_new_valid[2] = 1'b1; cycle();
    clear_inputs();
    check("A_vc_active_c4", vc_active[2], 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); pop = 4'b0100; settle();
      check("A_out_vc", out_vc, 4'b1000);
      check("A_out_valid", out_valid, 1'b1);
      if (i > 0) check("A_credit", {credit_valid, credit_vc}, 3'b110);
      cycle();
    end
    clear_inputs();
    check("A_credit_c8", {credit_valid, credit_vc}, 3'b110);
    check("A_idle_c8", {vc_active[2], vc_req[2]}, 2'b00);
    cycle();
    check("A_no_credit_c9", credit_valid, 1'b0);

    // Single-flit packet on VC0 forwarded through the grant bypass.
    clear_inputs(); set_push(0, 1, 1, 3, 32'hB0); cycle();
    clear_inputs(); cycle();
    check("B_vc_req", vc_req[0], 1'b1);
    vc_new[0] = 4'b0010; vc_new_valid[0] = 1'b1; pop = 4'b0001; settle();
    check("B_out_valid", out_valid, 1'b1);
    check("B_out_vc", out_vc, 4'b0010);
    check("B_out_ctl", {out_head, out_tail}, 2'b11);
    cycle();
    clear_inputs();
    check("B_no_active", {vc_active[0], vc_req[0]}, 2'b00);
    check("B_credit", {credit_valid, credit_vc}, 3'b100);
    cycle();
    check("B_one_credit", credit_valid, 1'b0);
    check("B_still_idle", vc_active[0], 1'b0);

    // Overflow on VC1, then push and pop of the full VC in the same cycle.
    for (int i = 0; i < 8; i++) begin
      clear_inputs(); set_push(1, i == 0, i == 7, 1, 32'hC00 + 32'(i)); cycle();
    end
    clear_inputs(); set_push(1, 0, 0, 1, 32'hC08); cycle();
    check("C_overflow", err, 3'b001);
    clear_inputs(); vc_new[1] = 4'b0100; vc_new_valid[1] = 1'b1; cycle();
    clear_inputs(); pop = 4'b0010; set_push(1, 1, 1, 2, 32'hC09); cycle();
    check("C_push_pop_full", err, 3'b001);
    pops_seen = 0;
    n = 0;
    while (q[1].size() > 0 && n < 40) begin
      clear_inputs(); auto_drive(4'b0010, 0); cycle(); n++;
    end
    check("C_drain_bound", n < 40, 1'b1);
    check("C_drained", pops_seen, 8);
    check("C_empty", not_empty[1], 1'b0);

    // Underflow on empty VC3, then pop of VC0 waiting for a grant.
    do_reset();
    pop = 4'b1000; settle();
    check("D_out_valid_empty", out_valid, 1'b0);
    cycle();
    clear_inputs();
    check("D_underflow", err, 3'b010);
    check("D_no_credit", credit_valid, 1'b0);
    set_push(0, 1, 0, 4, 32'hD0); cycle();
    clear_inputs(); cycle();
    check("D_wait", vc_req[0], 1'b1);
    pop = 4'b0001; settle();
    check("D_out_valid_wait", out_valid, 1'b0);
    cycle();
    clear_inputs();
    check("D_proto", err, 3'b110);
    check("D_no_credit2", credit_valid, 1'b0);

    // Interleaved 20-flit packets on VC0 and VC1, wrapping both FIFOs.
    do_reset();
    credits_seen = 0; pops_seen = 0; pushed = 0; n = 0;
    while (credits_seen < 40 && n < 400) begin
      clear_inputs();
      if (pushed < 40)
        set_push(pushed % 2, (pushed / 2) == 0, (pushed / 2) == 19, pushed / 2,
                 32'((pushed % 2) << 16) | 32'(pushed / 2));
      auto_drive(4'b0011, n % 2);
      cycle();
      if (pushed < 40) pushed++;
      n++;
    end
    check("E_bound", n < 400, 1'b1);
    check("E_credits", credits_seen, 40);
    check("E_pops", pops_seen, 40);
    check("E_err", err, 3'b000);

    // Reset while VC2 holds three flits and a downstream VC.
    do_reset();
    clear_inputs(); set_push(2, 1, 0, 7, 32'hF0); cycle();
    clear_inputs(); set_push(2, 0, 0, 7, 32'hF1); cycle();
    clear_inputs(); set_push(2, 0, 0, 7, 32'hF2); cycle();
    clear_inputs(); vc_new[2] = 4'b0001; vc_new_valid[2] = 1'b1; cycle();
    clear_inputs();
    check("F_active", vc_active[2], 1'b1);
    check("F_not_empty", not_empty[2], 1'b1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("F_not_empty_rst", not_empty, 4'b0000);
    check("F_fsm_rst", {vc_active, vc_req}, 8'h00);
    check("F_credit_rst", {credit_valid, credit_vc}, 3'b000);
    check("F_err_rst", err, 3'b000);
    check("F_route_rst", route_out, 20'd0);
    check("F_out_rst", {out_valid, out_vc}, 5'b00000);
    credits_seen = 0;
    repeat (3) cycle();
    check("F_no_credits", credits_seen, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      clear_inputs();
      if ($urandom_range(1, 0) == 1)
        set_push(int'($urandom_range(3, 0)), $urandom_range(2, 0) == 0,
                 $urandom_range(2, 0) == 0, int'($urandom_range(31, 0)), $urandom);
      r = int'($urandom_range(7, 0));
      if (r < 5)       pop[$urandom_range(3, 0)] = 1'b1;
      else if (r == 5) pop = 4'b0101;
      for (int v = 0; v < nv; v++)
        if ($urandom_range(3, 0) == 0) begin
          vc_new_valid[v] = 1'b1;
          vc_new[v]       = 4'b0001 << $urandom_range(3, 0);
        end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
